multicycle_ctrl_fsm: RTL

Multi-cycle main control unit for the MIPS datapath: sequences fetch, decode, execute, memory and write-back, and drives the ALU, register-file, memory and PC enables cycle by cycle. It produces the 3-bit `AluOp` consumed by the ALU control decoder. It also supports optional memory wait states.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/opcode_class_dec.sv | 45 ++++
 rtl/multicycle_ctrl_fsm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit: FSM states,
// opcode classes, opcode constants and the ALU / mux select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump
    } state_e;

    typedef enum logic [2:0] {
        ClsMem,
        ClsR,
        ClsI,
        ClsBr,
        ClsJ,
        ClsIll
    } op_class_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpBgtz  = 6'b000111;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Must match the encoding expected by the ALU control decoder.
    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluRtype = 3'b010;
    localparam logic [2:0] AluAndi  = 3'b100;
    localparam logic [2:0] AluOri   = 3'b101;
    localparam logic [2:0] AluBgtz  = 3'b110;
    localparam logic [2:0] AluSlti  = 3'b111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode decoder: instruction class plus the per-opcode AluOp
// used by the execute and branch states.
module opcode_class_dec (
    input  logic [5:0] opcode_i,
    output logic [2:0] class_o,
    output logic [2:0] alu_op_o
);
    import ctrl_pkg::*;

    always_comb begin
        class_o  = ClsIll;
        alu_op_o = AluAdd;
        case (opcode_i)
            OpLw, OpSw: class_o = ClsMem;
            OpRtype: begin
                class_o  = ClsR;
                alu_op_o = AluRtype;
            end
            OpAddi: class_o = ClsI;
            OpAndi: begin
                class_o  = ClsI;
                alu_op_o = AluAndi;
            end
            OpOri: begin
                class_o  = ClsI;
                alu_op_o = AluOri;
            end
            OpSlti: begin
                class_o  = ClsI;
                alu_op_o = AluSlti;
            end
            OpBeq, OpBne: begin
                class_o  = ClsBr;
                alu_op_o = AluSub;
            end
            OpBgtz: begin
                class_o  = ClsBr;
                alu_op_o = AluBgtz;
            end
            OpJ:     class_o = ClsJ;
            default: class_o = ClsIll;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM (fetch/decode/execute/memory/write-back).
// Define CTRL_MEM_WAIT_EN to stall FETCH, MEM_RD and MEM_WR on MemReady.
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] AluOp,
    output logic       Illegal
);
    import ctrl_pkg::*;

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    logic [5:0] dec_opcode;
    logic [2:0] dec_class;
    logic [2:0] dec_alu_op;
    logic       mem_rdy;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_rdy = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_rdy          = 1'b1;
`endif

    // Live IR only in DECODE; afterwards the latched copy drives the decoder.
    assign dec_opcode = (state_q == StDecode) ? Opcode : opcode_q;

    opcode_class_dec u_dec (
        .opcode_i (dec_opcode),
        .class_o  (dec_class),
        .alu_op_o (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= Opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (mem_rdy) state_d = StDecode;
            StDecode: begin
                case (dec_class)
                    ClsMem:  state_d = StMemAddr;
                    ClsR:    state_d = StRExec;
                    ClsI:    state_d = StIExec;
                    ClsBr:   state_d = StBranch;
                    ClsJ:    state_d = StJump;
                    default: state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = (opcode_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (mem_rdy) state_d = StMemWb;
            StMemWr:   if (mem_rdy) state_d = StFetch;
            StRExec:   state_d = StRWb;
            StIExec:   state_d = StIWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = SrcBReg;
        PCSource = PcSrcAlu;
        AluOp    = AluAdd;
        Illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    MemRead  = 1'b1;
                    IRWrite  = mem_rdy;
                    PCEn     = mem_rdy;
                    AluSrcB  = SrcBFour;
                    PCSource = PcSrcAlu;
                end
                StDecode: begin
                    AluSrcB = SrcBImmSh;
                    Illegal = (dec_class == ClsIll);
                end
                StMemAddr: begin
                    AluSrcA = 1'b1;
                    AluSrcB = SrcBImm;
                end
                StMemRd: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                StMemWr: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                StRExec: begin
                    AluSrcA = 1'b1;
                    AluSrcB = SrcBReg;
                    AluOp   = AluRtype;
                end
                StRWb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                StIExec: begin
                    AluSrcA = 1'b1;
                    AluSrcB = SrcBImm;
                    AluOp   = dec_alu_op;
                end
                StIWb: RegWrite = 1'b1;
                StBranch: begin
                    AluSrcA  = 1'b1;
                    AluSrcB  = SrcBReg;
                    PCSource = PcSrcAluOut;
                    AluOp    = dec_alu_op;
                    PCEn     = (opcode_q == OpBne) ? ~Zero : Zero;
                end
                StJump: begin
                    PCSource = PcSrcJump;
                    PCEn     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
